ldst_control_seq: RTL and testbench
===================================

Name: ldst_control_seq

Overview:
- Hardwired control sequencer generating the per-step datapath strobes for instruction fetch plus ld, ldi and st.
- Replaces the hand-driven T0..T7 control sequences used today to exercise Datapath.
- Generalises the fixed-timing sequence with parametrised opcode encodings, a mem_ready handshake (variable-latency memory) with a wait-timeout, continuous back-to-back execution, and fault reporting.
- Sits between memory/IR decode and the Datapath control inputs.

Parameters:
OPW, 5, opcode width (ir_opcode = IR[31:32-OPW])
OP_LD, 5'b00000, ld opcode
OP_LDI, 5'b00001, ldi opcode
OP_ST, 5'b00010, st opcode
ALU_ADD, 5'b00011, op_sel value for address add
MEM_TIMEOUT, 15, maximum memory wait cycles before fault (1..255)

Ports:
clk  in  1  clock, all state changes on rising edge
clr  in  1  reset
run  in  1  level; high = fetch/execute instructions continuously
ir_opcode  in  OPW  opcode field of IR
mem_ready  in  1  memory access completes this cycle
PC_out, Zlo_out, MDR_out, R_out, C_out, BAout  out  1 each  bus drive strobes
MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd, Rin  out  1 each  register load strobes
Gra, Grb  out  1 each  select/encode register field selects
IncPC, Read, Write  out  1 each  PC increment and memory strobes
op_sel  out  5  ALU operation select
busy  out  1  high in any state except IDLE and FAULT
done  out  1  one-cycle pulse, instruction retired
fault  out  1  sticky; high in FAULT
state  out  4  current state code, debug

Behaviour:
- Interface: one clock `clk`; `clr` is asynchronous and active-low.
- clr=0 forces IDLE immediately, mid-instruction included, with every output 0. Strobes are Moore-decoded from the state register and are all 0 in IDLE.
- State codes: IDLE=0, T0..T7=1..8, T1W=9, T6W=10, T7W=11, DONE=12, FAULT=13.
- IDLE: move to T0 when run=1.
- T0: PC_out, MAR_rd, IncPC, Zlo_rd.
- T1: Zlo_out, PC_rd, Read, MDR_rd. Go to T2 if mem_ready, otherwise T1W.
- T1W: Read, MDR_rd. Stay until mem_ready, then go to T2.
- T2: MDR_out, IR_rd.
- T3: latch ir_opcode into op_q.
  - op_q not in {OP_LD, OP_LDI, OP_ST}: go to FAULT; no T3 strobes are asserted.
  - Otherwise: Grb, BAout, R_out, Y_rd.
- T4: C_out, op_sel=ALU_ADD, Zlo_rd. op_sel=0 in all other states.
- T5:
  - ldi: Zlo_out, Gra, Rin, then go to DONE.
  - ld/st: Zlo_out, MAR_rd.
- T6:
  - ld: Read, MDR_rd. Go to T7 on mem_ready, else T6W (Read, MDR_rd held until mem_ready).
  - st: Gra, R_out, MDR_rd with Read=0, so MDR loads from the bus.
- T7:
  - ld: MDR_out, Gra, Rin, then go to DONE.
  - st: Write. Go to DONE on mem_ready, else T7W (Write held until mem_ready).
- DONE: done=1. Go to T0 if run=1, else IDLE.
- run falling mid-instruction has no effect; the instruction completes.
- Wait counter:
  - 8 bits; cleared on entry to T1, T6(ld) and T7(st); increments each cycle spent in a W state.
  - If the counter reaches MEM_TIMEOUT while mem_ready=0, go to FAULT.
  - mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT wins, and the sequence proceeds.
- FAULT: all strobes 0, fault=1, busy=0. Left only via clr.
- mem_ready outside memory states is ignored.
- At most one bus-drive strobe is asserted per state; the bench checks this.

Test Plan:
- ld (OP_LD), mem_ready tied 1, run pulsed 1 cycle:
  - states 1,2,3,4,5,6,7,8,12,0 on consecutive cycles;
  - T4 has op_sel=5'b00011;
  - done high exactly at cycle 9 after leaving IDLE.
- ld with mem_ready low for 3 cycles after T6 entry -> three T6W cycles with Read=MDR_rd=1, then T7. Total 12 cycles to done.
- ldi with mem_ready=1 -> T5 asserts Zlo_out,Gra,Rin; DONE follows T5. T6/T7 never visited.
- st with run held 1 and mem_ready=1:
  - T6 asserts Gra,R_out,MDR_rd with Read=0; T7 asserts Write;
  - DONE goes directly to T0 with no IDLE cycle.
- Opcode 5'b11111 -> FAULT after T3; fault=1, busy=0, strobes 0. run toggling does not leave FAULT; clr=0 returns IDLE.
- mem_ready held 0 in T1 with MEM_TIMEOUT=15 -> FAULT after 15 T1W cycles. Separately, clr=0 asserted mid-T4 drops op_sel, C_out and Zlo_rd to 0 before the next clock edge.

Source files
------------

// File: rtl/ldst_control_seq.sv
// Hardwired control sequencer for instruction fetch plus ld/ldi/st.
// Drives registered Datapath strobes and handshakes variable-latency memory.
module ldst_control_seq #(
   parameter int unsigned    OPW         = 5,
   parameter logic [OPW-1:0] OP_LD       = OPW'(0),
   parameter logic [OPW-1:0] OP_LDI      = OPW'(1),
   parameter logic [OPW-1:0] OP_ST       = OPW'(2),
   parameter logic [4:0]     ALU_ADD     = 5'b00011,
   parameter int unsigned    MEM_TIMEOUT = 15
) (
   input  logic           clk,
   input  logic           clr,
   input  logic           run,
   input  logic [OPW-1:0] ir_opcode,
   input  logic           mem_ready,
   output logic           PC_out,
   output logic           Zlo_out,
   output logic           MDR_out,
   output logic           R_out,
   output logic           C_out,
   output logic           BAout,
   output logic           MAR_rd,
   output logic           Zlo_rd,
   output logic           PC_rd,
   output logic           MDR_rd,
   output logic           IR_rd,
   output logic           Y_rd,
   output logic           Rin,
   output logic           Gra,
   output logic           Grb,
   output logic           IncPC,
   output logic           Read,
   output logic           Write,
   output logic [4:0]     op_sel,
   output logic           busy,
   output logic           done,
   output logic           fault,
   output logic [3:0]     state
);

   localparam int unsigned CW = 8;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,  S_T0  = 4'd1,  S_T1  = 4'd2,  S_T2   = 4'd3,
      S_T3   = 4'd4,  S_T4  = 4'd5,  S_T5  = 4'd6,  S_T6   = 4'd7,
      S_T7   = 4'd8,  S_T1W = 4'd9,  S_T6W = 4'd10, S_T7W  = 4'd11,
      S_DONE = 4'd12, S_FAULT = 4'd13
   } state_t;

   typedef struct packed {
      logic pc_out, zlo_out, mdr_out, r_out, c_out, ba_out;
      logic mar_rd, zlo_rd, pc_rd, mdr_rd, ir_rd, y_rd, rin;
      logic gra, grb, inc_pc, rd, wr;
      logic [4:0] op_sel;
      logic busy, done, fault;
   } ctl_t;

   state_t         state_q, state_d;
   logic [OPW-1:0] op_q, op_d;
   logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
   logic           timeout;
   ctl_t           ctl_q;

   assign cnt_inc = cnt_q + CW'(1);
   assign timeout = (cnt_inc == CW'(MEM_TIMEOUT));

   // Moore strobe decode for a given state and latched opcode.
   function automatic ctl_t decode(input state_t s, input logic [OPW-1:0] op);
      ctl_t c;
      logic is_ld, is_ldi, is_st;
      c      = '0;
      is_ld  = (op == OP_LD);
      is_ldi = (op == OP_LDI);
      is_st  = (op == OP_ST);
      c.busy = (s != S_IDLE) && (s != S_FAULT);
      case (s)
         S_T0:  begin c.pc_out = 1'b1; c.mar_rd = 1'b1; c.inc_pc = 1'b1; c.zlo_rd = 1'b1; end
         S_T1:  begin c.zlo_out = 1'b1; c.pc_rd = 1'b1; c.rd = 1'b1; c.mdr_rd = 1'b1; end
         S_T1W, S_T6W: begin c.rd = 1'b1; c.mdr_rd = 1'b1; end
         S_T2:  begin c.mdr_out = 1'b1; c.ir_rd = 1'b1; end
         S_T3:  if (is_ld || is_ldi || is_st) begin
                   c.grb = 1'b1; c.ba_out = 1'b1; c.r_out = 1'b1; c.y_rd = 1'b1;
                end
         S_T4:  begin c.c_out = 1'b1; c.op_sel = ALU_ADD; c.zlo_rd = 1'b1; end
         S_T5:  begin
                   c.zlo_out = 1'b1;
                   if (is_ldi) begin c.gra = 1'b1; c.rin = 1'b1; end
                   else        c.mar_rd = 1'b1;
                end
         S_T6:  if (is_ld) begin c.rd = 1'b1; c.mdr_rd = 1'b1; end
                else begin c.gra = 1'b1; c.r_out = 1'b1; c.mdr_rd = 1'b1; end
         S_T7:  if (is_ld) begin c.mdr_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                else c.wr = 1'b1;
         S_T7W: c.wr = 1'b1;
         S_DONE:  c.done = 1'b1;
         S_FAULT: c.fault = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

   // Next-state, opcode capture and memory wait counter.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: if (run) state_d = S_T0;
         S_T0:   begin state_d = S_T1; cnt_d = '0; end
         S_T1:   state_d = mem_ready ? S_T2 : S_T1W;
         S_T1W, S_T6W, S_T7W: begin
            if (mem_ready)
               state_d = (state_q == S_T1W) ? S_T2 : (state_q == S_T6W) ? S_T7 : S_DONE;
            else if (timeout)
               state_d = S_FAULT;
            else
               cnt_d = cnt_inc;
         end
         // Opcode is captured as T3 is entered so T3 strobes stay Moore.
         S_T2:   begin state_d = S_T3; op_d = ir_opcode; end
         S_T3:   state_d = (op_q == OP_LD || op_q == OP_LDI || op_q == OP_ST) ? S_T4 : S_FAULT;
         S_T4:   state_d = S_T5;
         S_T5:   if (op_q == OP_LDI) state_d = S_DONE;
                 else begin state_d = S_T6; cnt_d = '0; end
         S_T6:   if (op_q == OP_LD) state_d = mem_ready ? S_T7 : S_T6W;
                 else begin state_d = S_T7; cnt_d = '0; end
         S_T7:   if (op_q == OP_LD) state_d = S_DONE;
                 else state_d = mem_ready ? S_DONE : S_T7W;
         S_DONE:  state_d = run ? S_T0 : S_IDLE;
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_FAULT;
      endcase
   end

   // Strobes are registered from the next state, so they track the state register exactly.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         cnt_q   <= '0;
         ctl_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         ctl_q   <= decode(state_d, op_d);
      end
   end

   assign PC_out  = ctl_q.pc_out;
   assign Zlo_out = ctl_q.zlo_out;
   assign MDR_out = ctl_q.mdr_out;
   assign R_out   = ctl_q.r_out;
   assign C_out   = ctl_q.c_out;
   assign BAout   = ctl_q.ba_out;
   assign MAR_rd  = ctl_q.mar_rd;
   assign Zlo_rd  = ctl_q.zlo_rd;
   assign PC_rd   = ctl_q.pc_rd;
   assign MDR_rd  = ctl_q.mdr_rd;
   assign IR_rd   = ctl_q.ir_rd;
   assign Y_rd    = ctl_q.y_rd;
   assign Rin     = ctl_q.rin;
   assign Gra     = ctl_q.gra;
   assign Grb     = ctl_q.grb;
   assign IncPC   = ctl_q.inc_pc;
   assign Read    = ctl_q.rd;
   assign Write   = ctl_q.wr;
   assign op_sel  = ctl_q.op_sel;
   assign busy    = ctl_q.busy;
   assign done    = ctl_q.done;
   assign fault   = ctl_q.fault;
   assign state   = state_q;

endmodule

// File: tb/tb_ldst_control_seq.sv
// Scoreboard bench for ldst_control_seq: expected state/strobe words are queued
// as each cycle is driven and compared shortly after the clock edge.
module tb_ldst_control_seq;

   localparam logic [3:0] S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3,
                          S_T3 = 4'd4, S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7,
                          S_T7 = 4'd8, S_T1W = 4'd9, S_T6W = 4'd10, S_T7W = 4'd11,
                          S_DONE = 4'd12, S_FAULT = 4'd13;
   localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;
   localparam logic [4:0] OP_BAD = 5'b11111, ALU_ADD = 5'b00011;

   logic clk, clr, run, mem_ready;
   logic [4:0] ir_opcode;
   logic PC_out, Zlo_out, MDR_out, R_out, C_out, BAout;
   logic MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd, Rin;
   logic Gra, Grb, IncPC, Read, Write;
   logic [4:0] op_sel;
   logic busy, done, fault;
   logic [3:0] state;
   logic [25:0] obs;

   typedef struct packed {
      logic [3:0]  st;
      logic [25:0] vec;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int checks = 0;
   int errors = 0;

   ldst_control_seq #(
      .OPW(5), .OP_LD(OP_LD), .OP_LDI(OP_LDI), .OP_ST(OP_ST),
      .ALU_ADD(ALU_ADD), .MEM_TIMEOUT(15)
   ) dut (
      .clk(clk), .clr(clr), .run(run), .ir_opcode(ir_opcode), .mem_ready(mem_ready),
      .PC_out(PC_out), .Zlo_out(Zlo_out), .MDR_out(MDR_out), .R_out(R_out),
      .C_out(C_out), .BAout(BAout), .MAR_rd(MAR_rd), .Zlo_rd(Zlo_rd), .PC_rd(PC_rd),
      .MDR_rd(MDR_rd), .IR_rd(IR_rd), .Y_rd(Y_rd), .Rin(Rin), .Gra(Gra), .Grb(Grb),
      .IncPC(IncPC), .Read(Read), .Write(Write), .op_sel(op_sel), .busy(busy),
      .done(done), .fault(fault), .state(state)
   );

   assign obs = {PC_out, Zlo_out, MDR_out, R_out, C_out, BAout, MAR_rd, Zlo_rd, PC_rd,
                 MDR_rd, IR_rd, Y_rd, Rin, Gra, Grb, IncPC, Read, Write,
                 op_sel, busy, done, fault};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference strobe table, written from the state descriptions.
   function automatic logic [25:0] exp_vec(input logic [3:0] s, input logic [4:0] op);
      logic pco, zlo, mdro, ro, co, bao, mar, zrd, pcr, mdr, ir, y, rin, gra, grb, inc, rd, wr;
      logic bsy, dn, flt;
      logic [4:0] ops;
      pco = 0; zlo = 0; mdro = 0; ro = 0; co = 0; bao = 0; mar = 0; zrd = 0; pcr = 0;
      mdr = 0; ir = 0; y = 0; rin = 0; gra = 0; grb = 0; inc = 0; rd = 0; wr = 0;
      dn = 0; flt = 0; ops = 5'd0;
      bsy = (s != S_IDLE) && (s != S_FAULT);
      case (s)
         S_T0:  begin pco = 1; mar = 1; inc = 1; zrd = 1; end
         S_T1:  begin zlo = 1; pcr = 1; rd = 1; mdr = 1; end
         S_T1W: begin rd = 1; mdr = 1; end
         S_T2:  begin mdro = 1; ir = 1; end
         S_T3:  if (op == OP_LD || op == OP_LDI || op == OP_ST) begin grb = 1; bao = 1; ro = 1; y = 1; end
         S_T4:  begin co = 1; ops = ALU_ADD; zrd = 1; end
         S_T5:  if (op == OP_LDI) begin zlo = 1; gra = 1; rin = 1; end
                else begin zlo = 1; mar = 1; end
         S_T6:  if (op == OP_LD) begin rd = 1; mdr = 1; end
                else begin gra = 1; ro = 1; mdr = 1; end
         S_T6W: begin rd = 1; mdr = 1; end
         S_T7:  if (op == OP_LD) begin mdro = 1; gra = 1; rin = 1; end
                else wr = 1;
         S_T7W: wr = 1;
         S_DONE:  dn = 1;
         S_FAULT: flt = 1;
         default: ;
      endcase
      return {pco, zlo, mdro, ro, co, bao, mar, zrd, pcr, mdr, ir, y, rin, gra, grb, inc,
              rd, wr, ops, bsy, dn, flt};
   endfunction

   // Queue the expectation for the next edge, then advance to the following negedge.
   task automatic tick(input logic [3:0] es, input logic [4:0] op);
      exp_t e;
      e.st  = es;
      e.vec = exp_vec(es, op);
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Scoreboard: pop one expectation per edge and compare just after it.
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         checks++;
         if (state !== mon_e.st) begin
            errors++;
            $display("FAIL state: got %0d want %0d at %0t", state, mon_e.st, $time);
         end
         checks++;
         if (obs !== mon_e.vec) begin
            errors++;
            $display("FAIL strobes (state %0d): got %b want %b", mon_e.st, obs, mon_e.vec);
         end
         // BAout only qualifies R_out (reads R0 as zero), so they count as one drive.
         checks++;
         if ($countones({PC_out, Zlo_out, MDR_out, R_out | BAout, C_out}) > 1) begin
            errors++;
            $display("FAIL bus_exclusive (state %0d): got %b want at most one",
                     state, {PC_out, Zlo_out, MDR_out, R_out | BAout, C_out});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      clr = 1'b0; run = 1'b0; mem_ready = 1'b0; ir_opcode = OP_LD;
      repeat (2) @(negedge clk);
      checks++;
      if (state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
      checks++;
      if (obs !== 26'd0) begin errors++; $display("FAIL reset_outputs: got %b want 0", obs); end
      clr = 1'b1;
      tick(S_IDLE, OP_LD);
   endtask

   task automatic test_ld();
      logic [3:0] seq [9] = '{S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_DONE, S_IDLE};
      int done_cyc = 0;
      ir_opcode = OP_LD; mem_ready = 1'b1; run = 1'b1;
      tick(S_T0, OP_LD);
      run = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick(seq[i], OP_LD);
         if (done === 1'b1 && done_cyc == 0) done_cyc = i + 2;
         if (seq[i] == S_T4) begin
            checks++;
            if (op_sel !== ALU_ADD) begin errors++; $display("FAIL ld_op_sel: got %b want %b", op_sel, ALU_ADD); end
         end
      end
      checks++;
      if (done_cyc != 9) begin errors++; $display("FAIL ld_done_cycle: got %0d want 9", done_cyc); end
   endtask

   task automatic test_ld_wait();
      logic [3:0] pre [6] = '{S_T1, S_T2, S_T3, S_T4, S_T5, S_T6};
      int done_cyc = 0;
      int cyc = 1;
      ir_opcode = OP_LD; mem_ready = 1'b1; run = 1'b1;
      tick(S_T0, OP_LD);
      run = 1'b0;
      foreach (pre[i]) begin tick(pre[i], OP_LD); cyc++; end
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin tick(S_T6W, OP_LD); mem_ready = 1'b1; end
         else tick(S_T6W, OP_LD);
         cyc++;
         checks++;
         if ({Read, MDR_rd} !== 2'b11) begin errors++; $display("FAIL ld_wait_strobes: got %b want 11", {Read, MDR_rd}); end
      end
      tick(S_T7, OP_LD); cyc++;
      tick(S_DONE, OP_LD); cyc++;
      if (done === 1'b1) done_cyc = cyc;
      tick(S_IDLE, OP_LD);
      checks++;
      if (done_cyc != 12) begin errors++; $display("FAIL ld_wait_done_cycle: got %0d want 12", done_cyc); end
   endtask

   task automatic test_ldi();
      logic [3:0] seq [6] = '{S_T1, S_T2, S_T3, S_T4, S_T5, S_DONE};
      ir_opcode = OP_LDI; mem_ready = 1'b1; run = 1'b1;
      tick(S_T0, OP_LDI);
      run = 1'b0;
      foreach (seq[i]) begin
         tick(seq[i], OP_LDI);
         if (seq[i] == S_T5) begin
            checks++;
            if ({Zlo_out, Gra, Rin, MAR_rd} !== 4'b1110) begin
               errors++; $display("FAIL ldi_t5: got %b want 1110", {Zlo_out, Gra, Rin, MAR_rd});
            end
         end
      end
      tick(S_IDLE, OP_LDI);
   endtask

   task automatic test_st_back_to_back();
      logic [3:0] seq [8] = '{S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_DONE};
      ir_opcode = OP_ST; mem_ready = 1'b1; run = 1'b1;
      tick(S_T0, OP_ST);
      foreach (seq[i]) begin
         tick(seq[i], OP_ST);
         if (seq[i] == S_T6) begin
            checks++;
            if ({Gra, R_out, MDR_rd, Read} !== 4'b1110) begin
               errors++; $display("FAIL st_t6: got %b want 1110", {Gra, R_out, MDR_rd, Read});
            end
         end
      end
      tick(S_T0, OP_ST);
      checks++;
      if (state !== S_T0) begin errors++; $display("FAIL st_b2b_restart: got %0d want 1", state); end
      run = 1'b0;
      foreach (seq[i]) tick(seq[i], OP_ST);
      tick(S_IDLE, OP_ST);
   endtask

   // ready arrives in the very cycle the wait counter would expire.
   task automatic test_st_timeout_boundary();
      logic [3:0] seq [6] = '{S_T1, S_T2, S_T3, S_T4, S_T5, S_T6};
      ir_opcode = OP_ST; mem_ready = 1'b1; run = 1'b1;
      tick(S_T0, OP_ST);
      run = 1'b0;
      foreach (seq[i]) tick(seq[i], OP_ST);
      tick(S_T7, OP_ST);
      mem_ready = 1'b0;
      tick(S_T7W, OP_ST);
      for (int i = 0; i < 14; i++) tick(S_T7W, OP_ST);
      mem_ready = 1'b1;
      tick(S_DONE, OP_ST);
      checks++;
      if (fault !== 1'b0) begin errors++; $display("FAIL st_boundary_fault: got %b want 0", fault); end
      tick(S_IDLE, OP_ST);
   endtask

   task automatic test_timeout();
      ir_opcode = OP_LD; mem_ready = 1'b1; run = 1'b1;
      tick(S_T0, OP_LD);
      run = 1'b0;
      tick(S_T1, OP_LD);
      mem_ready = 1'b0;
      for (int i = 0; i < 15; i++) tick(S_T1W, OP_LD);
      tick(S_FAULT, OP_LD);
      checks++;
      if ({fault, busy} !== 2'b10) begin errors++; $display("FAIL timeout_fault: got %b want 10", {fault, busy}); end
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin run = i[0]; tick(S_FAULT, OP_LD); end
      clr = 1'b0; run = 1'b0;
      #1;
      checks++;
      if ({state, fault} !== 5'd0) begin errors++; $display("FAIL timeout_clr: got %b want 0", {state, fault}); end
      @(negedge clk);
      clr = 1'b1;
   endtask

   task automatic test_bad_opcode();
      logic [3:0] seq [4] = '{S_T1, S_T2, S_T3, S_FAULT};
      ir_opcode = OP_BAD; mem_ready = 1'b1; run = 1'b1;
      tick(S_T0, OP_BAD);
      run = 1'b0;
      foreach (seq[i]) tick(seq[i], OP_BAD);
      checks++;
      if ({fault, busy, obs[25:8]} !== {2'b10, 18'd0}) begin
         errors++; $display("FAIL bad_op_fault: got %b want %b", {fault, busy, obs[25:8]}, {2'b10, 18'd0});
      end
      for (int i = 0; i < 4; i++) begin run = ~i[0]; tick(S_FAULT, OP_BAD); end
      clr = 1'b0; run = 1'b0;
      #1;
      checks++;
      if (state !== S_IDLE) begin errors++; $display("FAIL bad_op_clr: got %0d want 0", state); end
      @(negedge clk);
      clr = 1'b1;
      tick(S_IDLE, OP_BAD);
   endtask

   task automatic test_clr_mid_t4();
      logic [3:0] seq [4] = '{S_T1, S_T2, S_T3, S_T4};
      ir_opcode = OP_LD; mem_ready = 1'b1; run = 1'b1;
      tick(S_T0, OP_LD);
      run = 1'b0;
      foreach (seq[i]) tick(seq[i], OP_LD);
      clr = 1'b0;
      #1;
      checks++;
      if ({op_sel, C_out, Zlo_rd, state} !== 11'd0) begin
         errors++; $display("FAIL clr_mid_t4: got %b want 0", {op_sel, C_out, Zlo_rd, state});
      end
      @(negedge clk);
      clr = 1'b1;
      tick(S_IDLE, OP_LD);
   endtask

   initial begin
      test_reset();
      test_ld();
      test_ld_wait();
      test_ldi();
      test_st_back_to_back();
      test_st_timeout_boundary();
      test_timeout();
      test_bad_opcode();
      test_clr_mid_t4();
      repeat (2) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d want 0", sb.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
